// File: rtl/serial_subtractor_n.sv
// Digit-serial N-bit subtractor: d = ina - inb - bin, DIGIT bits per clock.
// Ports: clk, rst_n, start/ina/inb/bin in; busy, done, d, bout, ovf, zero out.
module serial_subtractor_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_err
    $error("serial_subtractor_n: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, r_q, d_q;
  logic             br_q, amsb_q, bmsb_q;
  logic             bout_q, ovf_q, zero_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT:0]         brc;
  logic [DIGIT-1:0]       dig;
  logic [WIDTH+DIGIT-1:0] r_cat;
  logic [WIDTH-1:0]       r_nxt;
  logic                   last;

  // Ripple chain of full-subtractor cells over the low DIGIT bits.
  assign brc[0] = br_q;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
    assign dig[gi] = a_q[gi] ^ b_q[gi] ^ brc[gi];
    assign brc[gi+1] = (~a_q[gi] & b_q[gi])
                     | (~(a_q[gi] ^ b_q[gi]) & brc[gi]);
  end

  // New digit enters at the top; after N shifts r holds the full result.
  assign r_cat = {dig, r_q};
  assign r_nxt = r_cat[WIDTH+DIGIT-1:DIGIT];
  assign last  = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      br_q   <= 1'b0;
      amsb_q <= 1'b0;
      bmsb_q <= 1'b0;
      cnt_q  <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q    <= ina;
            b_q    <= inb;
            r_q    <= '0;
            br_q   <= bin;
            amsb_q <= ina[WIDTH-1];
            bmsb_q <= inb[WIDTH-1];
            cnt_q  <= '0;
          end
        end
        RUN: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          r_q   <= r_nxt;
          br_q  <= brc[DIGIT];
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            d_q    <= r_nxt;
            bout_q <= brc[DIGIT];
            ovf_q  <= (amsb_q != bmsb_q) && (r_nxt[WIDTH-1] != amsb_q);
            zero_q <= ~|r_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor_n.sv
// Directed bench for serial_subtractor_n (DIGIT=1 and DIGIT=4 instances).
// Hand-computed vectors plus an arithmetic reference for the DIGIT=4 sweep.
module tb_serial_subtractor_n;

  logic       clk;
  logic       rst_n;

  logic       start, bin, busy, done, bout, ovf, zero;
  logic [7:0] ina, inb, d;

  logic       start4, bin4, busy4, done4, bout4, ovf4, zero4;
  logic [7:0] ina4, inb4, d4;

  int passes;
  int checks;

  serial_subtractor_n #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .ina(ina), .inb(inb),
    .bin(bin), .busy(busy), .done(done), .d(d), .bout(bout),
    .ovf(ovf), .zero(zero)
  );

  serial_subtractor_n #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .ina(ina4), .inb(inb4),
    .bin(bin4), .busy(busy4), .done(done4), .d(d4), .bout(bout4),
    .ovf(ovf4), .zero(zero4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // {bout, ovf, zero, d} from plain 9-bit arithmetic.
  function automatic logic [10:0] model(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic bi);
    logic [8:0] diff;
    logic       v;
    diff = {1'b0, a} - {1'b0, b} - {8'd0, bi};
    v = (a[7] != b[7]) && (diff[7] != a[7]);
    return {diff[8], v, (diff[7:0] == 8'd0), diff[7:0]};
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic bi, output int lat, output int nbusy);
    @(negedge clk);
    start = 1'b1; ina = a; inb = b; bin = bi;
    @(negedge clk);
    start = 1'b0;
    ina = 8'($urandom); inb = 8'($urandom); bin = 1'($urandom);
    lat = 0;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (busy) nbusy++;
  endtask

  task automatic op4(input logic [7:0] a, input logic [7:0] b,
                     input logic bi, output int lat);
    @(negedge clk);
    start4 = 1'b1; ina4 = a; inb4 = b; bin4 = bi;
    @(negedge clk);
    start4 = 1'b0;
    ina4 = 8'($urandom); inb4 = 8'($urandom); bin4 = 1'($urandom);
    lat = 0;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, nb, ndone;
    logic [7:0] dseen;
    logic [7:0] cv [4];
    passes = 0;
    checks = 0;
    rst_n = 1'b0;
    start = 1'b0; ina = '0; inb = '0; bin = 1'b0;
    start4 = 1'b0; ina4 = '0; inb4 = '0; bin4 = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out", {21'd0, bout, ovf, zero, d}, 32'd0);
    check("rst_out4", {21'd0, busy4, ovf4, zero4, d4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: 05 - 03
    op8(8'h05, 8'h03, 1'b0, lat, nb);
    check("t1_lat", lat, 32'd8);
    check("t1_d", {24'd0, d}, 32'h02);
    check("t1_flags", {29'd0, bout, ovf, zero}, 32'd0);
    check("t1_busy_cycles", nb, 32'd9);
    @(negedge clk);
    check("t1_idle", {30'd0, busy, done}, 32'd0);
    check("t1_hold", {24'd0, d}, 32'h02);

    // 2: underflow and signed overflow
    op8(8'h00, 8'h01, 1'b0, lat, nb);
    check("t2a_res", {21'd0, bout, ovf, zero, d}, {21'd0, 3'b100, 8'hFF});
    op8(8'h80, 8'h01, 1'b0, lat, nb);
    check("t2b_res", {21'd0, bout, ovf, zero, d}, {21'd0, 3'b010, 8'h7F});

    // 3: borrow-in to zero; positive minus negative overflow
    op8(8'h10, 8'h0F, 1'b1, lat, nb);
    check("t3a_res", {21'd0, bout, ovf, zero, d}, {21'd0, 3'b001, 8'h00});
    op8(8'h7F, 8'hFF, 1'b0, lat, nb);
    check("t3b_res", {21'd0, bout, ovf, zero, d}, {21'd0, 3'b110, 8'h80});

    // 4: start during RUN is ignored
    @(negedge clk);
    start = 1'b1; ina = 8'h05; inb = 8'h03; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; ina = 8'hAA; inb = 8'h00;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy_run", {31'd0, busy}, 32'd1);
    check("t4_hold_run", {24'd0, d}, 32'h80);
    ndone = 0;
    dseen = '0;
    repeat (12) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        dseen = d;
      end
    end
    check("t4_ndone", ndone, 32'd1);
    check("t4_d", {24'd0, dseen}, 32'h02);

    // 5: async reset mid-RUN
    @(negedge clk);
    start = 1'b1; ina = 8'h20; inb = 8'h01; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_out", {21'd0, bout, ovf, zero, d}, 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t5_no_done", ndone, 32'd0);
    op8(8'h20, 8'h01, 1'b0, lat, nb);
    check("t5_lat", lat, 32'd8);
    check("t5_res", {21'd0, bout, ovf, zero, d}, {21'd0, 3'b000, 8'h1F});

    // 6: DIGIT=4 instance
    op4(8'h3C, 8'h4B, 1'b0, lat);
    check("t6_lat", lat, 32'd2);
    check("t6_res", {21'd0, bout4, ovf4, zero4, d4}, {21'd0, 3'b100, 8'hF1});

    cv[0] = 8'h00; cv[1] = 8'h7F; cv[2] = 8'h80; cv[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        for (int k = 0; k < 2; k++) begin
          op4(cv[i], cv[j], 1'(k), lat);
          check("t6_corner", {21'd0, bout4, ovf4, zero4, d4},
                {21'd0, model(cv[i], cv[j], 1'(k))});
        end
      end
    end

    for (int n = 0; n < 1500; n++) begin
      logic [7:0] a, b;
      logic       bi;
      a  = 8'($urandom);
      b  = 8'($urandom);
      bi = 1'($urandom);
      op4(a, b, bi, lat);
      check("t6_sweep", {21'd0, bout4, ovf4, zero4, d4},
            {21'd0, model(a, b, bi)});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
